trojan_vector_sweeper: RTL
==========================

// Module: trojan_vector_sweeper
// PURPOSE
//  Synthesizable exhaustive/pseudo-random stimulus engine for trojan-detection benchmarks.
//  Drives an N_IN-bit vector into a DUT, waits SETTLE cycles, then samples the N_OUT-bit response.
//  Emits one {vector,response} record per vector over a valid/ready stream.
//  Replaces fixed 4-bit, 1-output file-writing benches with an on-chip, back-pressured sweep.
// PARAMETERS
//  N_IN    4   stimulus width, 2..16
//  N_OUT   1   DUT response width, 1..32
//  SETTLE  1   cycles between vector apply and response sample, 1..255
// PORTS
//  CK         in   1      clock, rising edge
//  reset      in   1      asynchronous, active-low reset
//  start      in   1      1-cycle pulse; begins a sweep when idle
//  mode       in   1      0 = binary count, 1 = LFSR; sampled at start only
//  vec_out    out  N_IN   stimulus to DUT
//  dut_resp   in   N_OUT  DUT response
//  rec_valid  out  1      record available
//  rec_ready  in   1      consumer accepts record
//  rec_vec    out  N_IN   vector of current record
//  rec_resp   out  N_OUT  sampled response of current record
//  busy       out  1      sweep in progress
//  done       out  1      1-cycle pulse after last record accepted
//  signature  out  N_OUT  MISR value (only when SWEEP_MISR_EN is defined)
// BEHAVIOUR
//  Reset (reset=0, async): state=IDLE; vec_out, rec_vec, rec_resp, signature = 0; rec_valid, busy, done = 0.
//  FSM: IDLE -> APPLY -> SAMPLE -> (HOLD) -> APPLY ... -> FIN -> IDLE.
//  IDLE: on start, latch mode; set vec_out to 0 (count) or 1 (LFSR); busy=1; go APPLY.
//    start while busy is ignored.
//  APPLY: hold vec_out for SETTLE cycles (down-counter loaded with SETTLE-1); then go SAMPLE.
//  SAMPLE: register rec_vec=vec_out and rec_resp=dut_resp; rec_valid=1 on the next cycle.
//  HOLD: rec_valid=1 with rec_vec/rec_resp stable until the rec_valid&&rec_ready cycle.
//    rec_valid never drops without a handshake.
//    On handshake: if last vector, go FIN; else advance vec_out and go APPLY.
//    With rec_ready tied high, each vector costs SETTLE+1 cycles.
//  Advance: count mode adds 1; last vector = all ones, no wrap.
//    LFSR mode: Fibonacci, taps from package table; seed 1.
//    Visits 2^N_IN-1 nonzero states; last = state whose successor is 1; all-zero never driven.
//  FIN: done=1 for one cycle; busy=0; rec_valid=0; vec_out holds last vector; go IDLE.
//  Reset mid-sweep: immediate abort to reset values; no done pulse.
//  Records per sweep: 2^N_IN (count) or 2^N_IN-1 (LFSR).
// CONFIGURATION
//  SWEEP_MISR_EN defined: N_OUT-bit MISR.
//    Cleared at start; updated with rec_resp on each record handshake.
//    Polynomial from package (N_OUT=1: plain XOR accumulate).
//    signature is final and stable from the done cycle until the next start.
//  SWEEP_MISR_EN undefined: no MISR logic; signature port tied to 0.
// STRUCTURE
//  Package sweep_pkg: state enum sweep_state_t {IDLE,APPLY,SAMPLE,HOLD,FIN}.
//  sweep_pkg: function lfsr_taps(width) returning maximal-length taps for 2..16.
//  sweep_pkg: function misr_poly(width).
//  Sub-module sweep_lfsr: N_IN-bit step logic (count/LFSR select, next value, is_last flag).
//  Sub-module sweep_misr: compiled only under SWEEP_MISR_EN.
// TESTING
//  1 N_IN=4, mode=0, SETTLE=1, rec_ready=1, DUT=&vec -> 16 records 0000..1111.
//    resp=1 only at 1111; done 32 cycles after apply of first vector.
//  2 N_IN=4, mode=1, DUT=^vec -> 15 distinct nonzero records; first vector 0001; never 0000; one done pulse.
//  3 rec_ready toggles 1-of-3 cycles -> rec_vec/rec_resp stable while rec_valid&&!rec_ready.
//    No record lost or duplicated.
//  4 SETTLE=3, DUT delays resp by 2 cycles -> every rec_resp matches the delayed function of rec_vec.
//  5 reset low during 6th record HOLD -> all outputs 0 same cycle.
//    A new start after release restarts from 0000.
//  6 SWEEP_MISR_EN, N_OUT=1, DUT=&vec, count mode -> signature=1 at done.
//    start pulsed while busy has no effect.

Source files
------------

// File: rtl/sweep_pkg.sv
// Shared types and polynomial tables for the trojan vector sweeper.
package sweep_pkg;

    typedef enum logic [2:0] {IDLE, APPLY, SAMPLE, HOLD, FIN} sweep_state_t;

    // Fibonacci tap masks (bit p-1 set for tap p) giving maximal-length sequences.
    function automatic logic [15:0] lfsr_taps(input int width);
        case (width)
            2:       return 16'h0003;
            3:       return 16'h0006;
            4:       return 16'h000C;
            5:       return 16'h0014;
            6:       return 16'h0030;
            7:       return 16'h0060;
            8:       return 16'h00B8;
            9:       return 16'h0110;
            10:      return 16'h0240;
            11:      return 16'h0500;
            12:      return 16'h0829;
            13:      return 16'h100D;
            14:      return 16'h2015;
            15:      return 16'h6000;
            16:      return 16'hD008;
            default: return 16'h0000;
        endcase
    endfunction

    // Galois feedback mask for the signature register; width 1 degenerates to XOR accumulate.
    function automatic logic [31:0] misr_poly(input int width);
        if (width <= 1)
            return 32'h0000_0000;
        else if (width <= 16)
            return {16'h0000, lfsr_taps(width)};
        else
            return 32'h04C1_1DB7;
    endfunction

endpackage

// File: rtl/sweep_lfsr.sv
// Next-vector logic: binary increment or Fibonacci LFSR step, plus last-vector detect.
module sweep_lfsr
    import sweep_pkg::*;
#(
    parameter int N_IN = 4
) (
    input  logic [N_IN-1:0] vec_i,
    input  logic            mode_i,
    output logic [N_IN-1:0] next_o,
    output logic            is_last_o
);

    localparam logic [15:0]     TAPS16 = lfsr_taps(N_IN);
    localparam logic [N_IN-1:0] TAPS   = TAPS16[N_IN-1:0];
    localparam logic [N_IN-1:0] ONE    = {{(N_IN-1){1'b0}}, 1'b1};

    logic            fb;
    logic [N_IN-1:0] lfsr_nxt;

    assign fb       = ^(vec_i & TAPS);
    assign lfsr_nxt = {vec_i[N_IN-2:0], fb};

    always_comb begin
        next_o    = vec_i + ONE;
        is_last_o = &vec_i;
        if (mode_i) begin
            next_o    = lfsr_nxt;
            // The sequence closes when it is about to return to the seed.
            is_last_o = (lfsr_nxt == ONE);
        end
    end

endmodule

// File: rtl/sweep_misr.sv
// Response compactor, built only when SWEEP_MISR_EN is defined.
`ifdef SWEEP_MISR_EN
module sweep_misr
    import sweep_pkg::*;
#(
    parameter int N_OUT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [N_OUT-1:0] data_i,
    output logic [N_OUT-1:0] sig_o
);

    localparam logic [31:0]      POLY32 = misr_poly(N_OUT);
    localparam logic [N_OUT-1:0] POLY   = POLY32[N_OUT-1:0];

    logic [N_OUT-1:0] sig_q;
    logic [N_OUT-1:0] sig_d;

    generate
        if (N_OUT == 1) begin : g_xor
            always_comb sig_d = sig_q ^ data_i;
        end else begin : g_galois
            always_comb
                sig_d = {sig_q[N_OUT-2:0], 1'b0} ^ (sig_q[N_OUT-1] ? POLY : '0) ^ data_i;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            sig_q <= '0;
        else if (clr_i)
            sig_q <= '0;
        else if (en_i)
            sig_q <= sig_d;
    end

    assign sig_o = sig_q;

endmodule
`endif

// File: rtl/trojan_vector_sweeper.sv
// Back-pressured exhaustive/LFSR stimulus sweeper emitting {vector,response} records.
// Optional MISR signature compaction is enabled with `define SWEEP_MISR_EN.
module trojan_vector_sweeper
    import sweep_pkg::*;
#(
    parameter int N_IN   = 4,
    parameter int N_OUT  = 1,
    parameter int SETTLE = 1
) (
    input  logic             CK,
    input  logic             reset,
    input  logic             start,
    input  logic             mode,
    output logic [N_IN-1:0]  vec_out,
    input  logic [N_OUT-1:0] dut_resp,
    output logic             rec_valid,
    input  logic             rec_ready,
    output logic [N_IN-1:0]  rec_vec,
    output logic [N_OUT-1:0] rec_resp,
    output logic             busy,
    output logic             done,
    output logic [N_OUT-1:0] signature
);

    localparam logic [7:0]      SETTLE_LD = 8'(SETTLE - 1);
    localparam logic [N_IN-1:0] ONE       = {{(N_IN-1){1'b0}}, 1'b1};

    sweep_state_t     state_q;
    logic             mode_q;
    logic [7:0]       cnt_q;
    logic [N_IN-1:0]  vec_q;
    logic [N_IN-1:0]  vec_d;
    logic             is_last;
    logic [N_IN-1:0]  rec_vec_q;
    logic [N_OUT-1:0] rec_resp_q;
    logic             rec_valid_q;
    logic             busy_q;
    logic             done_q;

    sweep_lfsr #(.N_IN(N_IN)) u_step (
        .vec_i     (vec_q),
        .mode_i    (mode_q),
        .next_o    (vec_d),
        .is_last_o (is_last)
    );

    // SAMPLE is the first cycle a record is offered; HOLD covers back-pressure stalls.
    always_ff @(posedge CK or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            mode_q      <= 1'b0;
            cnt_q       <= 8'd0;
            vec_q       <= '0;
            rec_vec_q   <= '0;
            rec_resp_q  <= '0;
            rec_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        mode_q  <= mode;
                        vec_q   <= mode ? ONE : '0;
                        cnt_q   <= SETTLE_LD;
                        busy_q  <= 1'b1;
                        state_q <= APPLY;
                    end
                end
                APPLY: begin
                    if (cnt_q == 8'd0) begin
                        rec_vec_q   <= vec_q;
                        rec_resp_q  <= dut_resp;
                        rec_valid_q <= 1'b1;
                        state_q     <= SAMPLE;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                SAMPLE, HOLD: begin
                    if (rec_ready) begin
                        rec_valid_q <= 1'b0;
                        if (is_last) begin
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= FIN;
                        end else begin
                            vec_q   <= vec_d;
                            cnt_q   <= SETTLE_LD;
                            state_q <= APPLY;
                        end
                    end else begin
                        state_q <= HOLD;
                    end
                end
                FIN:     state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign vec_out   = vec_q;
    assign rec_vec   = rec_vec_q;
    assign rec_resp  = rec_resp_q;
    assign rec_valid = rec_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;

`ifdef SWEEP_MISR_EN
    sweep_misr #(.N_OUT(N_OUT)) u_misr (
        .clk    (CK),
        .rst_n  (reset),
        .clr_i  ((state_q == IDLE) && start),
        .en_i   (rec_valid_q && rec_ready),
        .data_i (rec_resp_q),
        .sig_o  (signature)
    );
`else
    assign signature = '0;
`endif

endmodule
